// File: rtl/multicycle_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared opcodes, FSM states, ALU codes and immediate decode.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_e;

    function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_e sel);
        logic [31:0] imm;
        case (sel)
            IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = {{20{ir[31]}}, ir[31:20]};
        endcase
        return imm;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_cpu_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_cpu_if
// Brief    : Instruction memory, data memory and IO bus of the multi-cycle core.
// Revision : 1.0
// ============================================================================
interface multicycle_cpu_if #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 8,
    parameter int DMEM_AW = 8
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic [DMEM_AW-1:0] dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_we;
    logic [DATA_W-1:0]  dmem_rdata;
    logic [7:0]         io_addr;
    logic [DATA_W-1:0]  io_dout;
    logic               io_we;
    logic [DATA_W-1:0]  io_din;

    modport master (
        output imem_addr, input imem_rdata,
        output dmem_addr, output dmem_wdata, output dmem_we, input dmem_rdata,
        output io_addr, output io_dout, output io_we, input io_din
    );

    modport slave (
        input imem_addr, output imem_rdata,
        input dmem_addr, input dmem_wdata, input dmem_we, output dmem_rdata,
        input io_addr, input io_dout, input io_we, output io_din
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_cpu_regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Brief    : 32-entry register file, two operand reads, one debug read, x0 = 0.
// Revision : 1.0
// ============================================================================
module regfile #(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic [4:0]        ra1_i,
    input  wire logic [4:0]        ra2_i,
    input  wire logic [4:0]        rad_i,
    output logic      [DATA_W-1:0] rd1_o,
    output logic      [DATA_W-1:0] rd2_o,
    output logic      [DATA_W-1:0] rdd_o,
    input  wire logic              we_i,
    input  wire logic [4:0]        wa_i,
    input  wire logic [DATA_W-1:0] wd_i
);
    logic [DATA_W-1:0] regs_q [32];

    // Contents are deliberately not reset; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
    assign rdd_o = (rad_i == 5'd0) ? '0 : regs_q[rad_i];
endmodule
`default_nettype wire

// File: rtl/multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_cpu
// Brief    : Five-state multi-cycle RV32 subset core with run/step gate.
// Revision : 1.0
// ============================================================================
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] PC_RESET = '0,
    parameter int                IMEM_AW  = 8,
    parameter int                DMEM_AW  = 8,
    parameter int                IO_BIT   = 10
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              run,
    multicycle_cpu_if.master       bus,
    input  wire logic [4:0]        m_rf_addr,
    output logic      [DATA_W-1:0] rf_data,
    output logic      [DATA_W-1:0] pc,
    output logic      [2:0]        state,
    output logic                   illegal
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
    logic [31:0]       ir_q, ir_d;
    logic              ill_q, ill_d;

    logic [DATA_W-1:0] rs1_val, rs2_val, imm, alu_b, alu_res, pc_plus4, rf_wd;
    logic              rf_we, use_imm, dmem_we, io_we;
    alu_op_e           alu_op;
    imm_e              imm_sel;
    logic [6:0]        opcode;

    assign opcode   = ir_q[6:0];
    assign imm      = DATA_W'($signed(imm_gen(ir_q, imm_sel)));
    assign alu_b    = use_imm ? imm : b_q;
    assign pc_plus4 = pc_q + DATA_W'(4);

    regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk   (clk),
        .ra1_i (bus.imem_rdata[19:15]),
        .ra2_i (bus.imem_rdata[24:20]),
        .rad_i (m_rf_addr),
        .rd1_o (rs1_val),
        .rd2_o (rs2_val),
        .rdd_o (rf_data),
        .we_i  (rf_we),
        .wa_i  (ir_q[11:7]),
        .wd_i  (rf_wd)
    );

    always_comb begin
        alu_op  = ALU_ADD;
        imm_sel = IMM_I;
        use_imm = 1'b1;
        case (opcode)
            OP_R: begin
                use_imm = 1'b0;
                case (ir_q[14:12])
                    3'b000:  alu_op = ir_q[30] ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_op = ALU_AND;
                    3'b110:  alu_op = ALU_OR;
                    3'b010:  alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_SW:  imm_sel = IMM_S;
            OP_BEQ: begin
                imm_sel = IMM_B;
                use_imm = 1'b0;
                alu_op  = ALU_SUB;
            end
            OP_JAL:  imm_sel = IMM_J;
            default: imm_sel = IMM_I;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_res = a_q - alu_b;
            ALU_AND: alu_res = a_q & alu_b;
            ALU_OR:  alu_res = a_q | alu_b;
            ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            default: alu_res = a_q + alu_b;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        ill_d   = ill_q;
        rf_we   = 1'b0;
        rf_wd   = alu_q;
        dmem_we = 1'b0;
        io_we   = 1'b0;
        case (state_q)
            FETCH: if (run) state_d = DECODE;
            // Operands come straight from the memory word; IR is loaded in parallel.
            DECODE: begin
                ir_d    = bus.imem_rdata;
                a_d     = rs1_val;
                b_d     = rs2_val;
                state_d = EXEC;
            end
            EXEC: begin
                alu_d = alu_res;
                case (opcode)
                    OP_R, OP_I:    state_d = WB;
                    OP_LW, OP_SW:  state_d = MEM;
                    OP_BEQ: begin
                        pc_d    = (alu_res == '0) ? pc_q + imm : pc_plus4;
                        state_d = FETCH;
                    end
                    OP_JAL: begin
                        rf_we   = 1'b1;
                        rf_wd   = pc_plus4;
                        pc_d    = pc_q + imm;
                        state_d = FETCH;
                    end
                    default: begin
                        ill_d   = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = FETCH;
                    end
                endcase
            end
            MEM: begin
                if (opcode == OP_SW) begin
                    io_we   = alu_q[IO_BIT];
                    dmem_we = ~alu_q[IO_BIT];
                    pc_d    = pc_plus4;
                    state_d = FETCH;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                rf_we = 1'b1;
                if (opcode == OP_LW) begin
                    rf_wd = alu_q[IO_BIT] ? bus.io_din : bus.dmem_rdata;
                end
                pc_d    = pc_plus4;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.imem_addr  = pc_q[IMEM_AW+1:2];
    assign bus.dmem_addr  = alu_q[DMEM_AW+1:2];
    assign bus.dmem_wdata = b_q;
    assign bus.dmem_we    = dmem_we;
    assign bus.io_addr    = alu_q[7:0];
    assign bus.io_dout    = b_q;
    assign bus.io_we      = io_we;

    assign pc      = pc_q;
    assign state   = state_q;
    assign illegal = ill_q;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_cpu
// Brief    : Directed vector table plus random instruction stream vs ISA model.
// Revision : 1.0
// ============================================================================
module tb_multicycle_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [4:0]  m_rf_addr = 5'd0;
    logic [31:0] rf_data, pc;
    logic [2:0]  state;
    logic        illegal;

    multicycle_cpu_if #(.DATA_W(32), .IMEM_AW(8), .DMEM_AW(8)) bus ();

    multicycle_cpu #(
        .DATA_W(32), .PC_RESET(32'h0), .IMEM_AW(8), .DMEM_AW(8), .IO_BIT(10)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .bus(bus),
        .m_rf_addr(m_rf_addr), .rf_data(rf_data), .pc(pc),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // External synchronous-read memories
    logic [31:0] imem [256];
    logic [31:0] dmem [256];
    always @(posedge clk) begin
        bus.imem_rdata <= imem[bus.imem_addr];
        bus.dmem_rdata <= dmem[bus.dmem_addr];
        if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
    end

    int dwe_cnt = 0, iwe_cnt = 0, both_cnt = 0;
    logic [7:0]  s_daddr, s_iaddr;
    logic [31:0] s_ddata, s_idata;
    always @(negedge clk) begin
        if (bus.dmem_we) begin dwe_cnt++; s_daddr = bus.dmem_addr; s_ddata = bus.dmem_wdata; end
        if (bus.io_we)   begin iwe_cnt++; s_iaddr = bus.io_addr;   s_idata = bus.io_dout;    end
        if (bus.dmem_we && bus.io_we) both_cnt++;
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] e_i(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
        logic [11:0] t = imm[11:0];
        return {t, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] e_s(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
        logic [11:0] t = imm[11:0];
        return {t[11:5], rs2, rs1, 3'b010, t[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] e_b(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
        logic [12:0] t = imm[12:0];
        return {t[12], t[10:5], rs2, rs1, 3'b000, t[4:1], t[11], 7'h63};
    endfunction
    function automatic logic [31:0] e_j(input int imm, input logic [4:0] rd);
        logic [20:0] t = imm[20:0];
        return {t[20], t[10:1], t[11], t[19:12], rd, 7'h6f};
    endfunction

    // ---------------- architectural reference model ----------------
    logic [31:0] m_reg [32];
    logic [31:0] m_dmem [256];
    logic [31:0] m_pc = 32'h0;
    logic        m_ill = 1'b0;
    logic [7:0]  e_daddr, e_iaddr;
    logic [31:0] e_ddata, e_idata;

    task automatic model_exec(input logic [31:0] ins, input logic [31:0] din, output int cyc,
                              output int dwe, output int iwe, output logic wr, output logic [4:0] rd);
        logic [31:0] a, b, ii, is, ib, ij, addr, res;
        a  = m_reg[ins[19:15]];
        b  = m_reg[ins[24:20]];
        rd = ins[11:7];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        dwe = 0; iwe = 0; wr = 1'b0; res = 32'h0;
        case (ins[6:0])
            7'h33: begin
                case (ins[14:12])
                    3'd0:    res = ins[30] ? a - b : a + b;
                    3'd7:    res = a & b;
                    3'd6:    res = a | b;
                    3'd2:    res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: res = a + b;
                endcase
                wr = 1'b1; m_pc = m_pc + 4; cyc = 4;
            end
            7'h13: begin res = a + ii; wr = 1'b1; m_pc = m_pc + 4; cyc = 4; end
            7'h03: begin
                addr = a + ii;
                res  = addr[10] ? din : m_dmem[addr[9:2]];
                wr = 1'b1; m_pc = m_pc + 4; cyc = 5;
            end
            7'h23: begin
                addr = a + is;
                if (addr[10]) begin iwe = 1; e_iaddr = addr[7:0]; e_idata = b; end
                else begin dwe = 1; e_daddr = addr[9:2]; e_ddata = b; m_dmem[addr[9:2]] = b; end
                m_pc = m_pc + 4; cyc = 4;
            end
            7'h63: begin m_pc = (a == b) ? m_pc + ib : m_pc + 4; cyc = 3; end
            7'h6f: begin res = m_pc + 4; wr = 1'b1; m_pc = m_pc + ij; cyc = 3; end
            default: begin m_ill = 1'b1; m_pc = m_pc + 4; cyc = 3; end
        endcase
        if (wr && rd != 5'd0) m_reg[rd] = res;
    endtask

    // ---------------- drivers ----------------
    task automatic step(output int cyc);
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0; cyc = 1;
        while (state != 3'd0 && cyc < 12) begin @(negedge clk); cyc++; end
    endtask

    task automatic read_rf(input logic [4:0] idx, output logic [31:0] v);
        m_rf_addr = idx; #1; v = rf_data;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic [31:0] din, input string tag);
        int cyc, mcyc, d0, i0, dwe, iwe;
        logic wr; logic [4:0] rd; logic [31:0] v;
        imem[m_pc[9:2]] = ins;
        bus.io_din = din;
        d0 = dwe_cnt; i0 = iwe_cnt;
        step(cyc);
        model_exec(ins, din, mcyc, dwe, iwe, wr, rd);
        chk({tag, " cycles"}, cyc, mcyc);
        chk({tag, " pc"}, pc, m_pc);
        chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, m_ill});
        chk({tag, " dmem_we pulses"}, dwe_cnt - d0, dwe);
        chk({tag, " io_we pulses"}, iwe_cnt - i0, iwe);
        if (dwe != 0) begin
            chk({tag, " dmem_addr"}, {24'd0, s_daddr}, {24'd0, e_daddr});
            chk({tag, " dmem_wdata"}, s_ddata, e_ddata);
        end
        if (iwe != 0) begin
            chk({tag, " io_addr"}, {24'd0, s_iaddr}, {24'd0, e_iaddr});
            chk({tag, " io_dout"}, s_idata, e_idata);
        end
        if (wr) begin
            read_rf(rd, v);
            chk({tag, " rd value"}, v, m_reg[rd]);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] din;
        logic [4:0]  ri;
        logic [31:0] rv;
        logic [31:0] pc;
        int          cyc;
        logic        ill;
    } vec_t;

    initial begin
        vec_t vt [19];
        logic [31:0] v, ins, old;
        int n, d0, i0, k, bad;

        for (int i = 0; i < 256; i++) begin imem[i] = 32'h0; dmem[i] = 32'h0; m_dmem[i] = 32'h0; end
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
        bus.io_din = 32'h0;

        vt[0]  = '{e_i(5, 0, 3'd0, 1, 7'h13),          0, 1, 32'd5,        32'h04, 4, 0};
        vt[1]  = '{e_i(-3, 0, 3'd0, 2, 7'h13),         0, 2, 32'hFFFFFFFD, 32'h08, 4, 0};
        vt[2]  = '{e_r(7'h00, 2, 1, 3'd0, 3),          0, 3, 32'd2,        32'h0C, 4, 0};
        vt[3]  = '{e_r(7'h20, 2, 1, 3'd0, 3),          0, 3, 32'd8,        32'h10, 4, 0};
        vt[4]  = '{e_r(7'h00, 1, 2, 3'd2, 3),          0, 3, 32'd1,        32'h14, 4, 0};
        vt[5]  = '{e_s(0, 1, 0),                       0, 1, 32'd5,        32'h18, 4, 0};
        vt[6]  = '{e_i(0, 0, 3'd2, 4, 7'h03),          0, 4, 32'd5,        32'h1C, 5, 0};
        vt[7]  = '{e_i(32'h400, 0, 3'd0, 5, 7'h13),    0, 5, 32'h400,      32'h20, 4, 0};
        vt[8]  = '{e_s(4, 1, 5),                       0, 1, 32'd5,        32'h24, 4, 0};
        vt[9]  = '{e_i(8, 5, 3'd2, 6, 7'h03),      32'hA5, 6, 32'hA5,       32'h28, 5, 0};
        vt[10] = '{e_i(7, 0, 3'd0, 0, 7'h13),          0, 0, 32'd0,        32'h2C, 4, 0};
        vt[11] = '{e_j(-28, 7),                        0, 7, 32'h30,       32'h10, 3, 0};
        vt[12] = '{e_b(-8, 1, 1),                      0, 1, 32'd5,        32'h08, 3, 0};
        vt[13] = '{e_j(8, 0),                          0, 0, 32'd0,        32'h10, 3, 0};
        vt[14] = '{e_b(-8, 2, 1),                      0, 1, 32'd5,        32'h14, 3, 0};
        vt[15] = '{e_j(12, 0),                         0, 0, 32'd0,        32'h20, 3, 0};
        vt[16] = '{e_j(12, 1),                         0, 1, 32'h24,       32'h2C, 3, 0};
        vt[17] = '{32'h00000000,                       0, 0, 32'd0,        32'h30, 3, 1};
        vt[18] = '{e_i(1, 0, 3'd0, 8, 7'h13),          0, 8, 32'd1,        32'h34, 4, 1};

        // Reset and hold with run low
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset pc", pc, 32'h0);
        chk("reset state", {29'd0, state}, 32'd0);
        chk("reset strobes", {30'd0, bus.dmem_we, bus.io_we}, 32'd0);
        chk("reset illegal", {31'd0, illegal}, 32'd0);
        repeat (20) @(negedge clk);
        chk("idle pc", pc, 32'h0);
        chk("idle state", {29'd0, state}, 32'd0);

        for (int i = 0; i < 19; i++) begin
            int c0;
            c0 = n_chk;
            run_instr(vt[i].ins, vt[i].din, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl pc", i), pc, vt[i].pc);
            chk($sformatf("vec%0d tbl ill", i), {31'd0, illegal}, {31'd0, vt[i].ill});
            read_rf(vt[i].ri, v);
            chk($sformatf("vec%0d tbl reg", i), v, vt[i].rv);
            if (i == 0) begin
                repeat (5) @(negedge clk);
                chk("halt pc", pc, 32'h4);
                chk("halt state", {29'd0, state}, 32'd0);
            end
            if (n_chk == c0) n_fail++;
        end
        chk("sw data word0", dmem[0], 32'd5);

        // Reset asserted during the MEM cycle of a store
        ins = e_s(12, 1, 0);
        imem[m_pc[9:2]] = ins;
        d0 = dwe_cnt; i0 = iwe_cnt;
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0; n = 0;
        while (state != 3'd2 && n < 10) begin @(negedge clk); n++; end
        chk("rstmem reach exec", {29'd0, state}, 32'd2);
        @(posedge clk); #1 rst = 1'b1; #1;
        chk("rstmem pc async", pc, 32'h0);
        chk("rstmem state async", {29'd0, state}, 32'd0);
        chk("rstmem strobes async", {30'd0, bus.dmem_we, bus.io_we}, 32'd0);
        @(negedge clk);
        chk("rstmem strobes", {30'd0, bus.dmem_we, bus.io_we}, 32'd0);
        @(negedge clk); rst = 1'b0;
        chk("rstmem dmem pulses", dwe_cnt - d0, 0);
        chk("rstmem io pulses", iwe_cnt - i0, 0);
        chk("rstmem word3", dmem[3], 32'h0);
        chk("rstmem illegal clr", {31'd0, illegal}, 32'd0);
        read_rf(5'd8, v);
        chk("rstmem reg persist", v, 32'd1);
        m_pc = 32'h0; m_ill = 1'b0;

        // Debug read racing a write-back to the same register
        begin
            int c, d, iw; logic w; logic [4:0] r;
            ins = e_i(32'h55, 0, 3'd0, 3, 7'h13);
            imem[0] = ins;
            old = m_reg[3];
            m_rf_addr = 5'd3;
            @(negedge clk); run = 1'b1;
            @(negedge clk); run = 1'b0; n = 0;
            while (state != 3'd4 && n < 10) begin @(negedge clk); n++; end
            chk("dbg reach wb", {29'd0, state}, 32'd4);
            #1 chk("dbg old value", rf_data, old);
            @(negedge clk); #1;
            chk("dbg new value", rf_data, 32'h55);
            model_exec(ins, 32'h0, c, d, iw, w, r);
            chk("dbg pc", pc, m_pc);
        end

        // Random stream: define every register, then mixed instructions
        for (int r = 1; r < 32; r++)
            run_instr(e_i($urandom_range(0, 4095), 0, 3'd0, r[4:0], 7'h13), 0, "init");
        for (int t = 0; t < 300; t++) begin
            logic [4:0] rd, rs1, rs2;
            rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
            k = $urandom_range(0, 10);
            case (k)
                0:  ins = e_r(7'h00, rs2, rs1, 3'd0, rd);
                1:  ins = e_r(7'h20, rs2, rs1, 3'd0, rd);
                2:  ins = e_r(7'h00, rs2, rs1, 3'd7, rd);
                3:  ins = e_r(7'h00, rs2, rs1, 3'd6, rd);
                4:  ins = e_r(7'h00, rs2, rs1, 3'd2, rd);
                5:  ins = e_i($urandom_range(0, 4095), rs1, 3'd0, rd, 7'h13);
                6:  ins = e_i($urandom_range(0, 4095), ($urandom_range(0, 1) != 0) ? 5'd0 : rs1, 3'd2, rd, 7'h03);
                7:  ins = e_s($urandom_range(0, 4095), rs2, ($urandom_range(0, 1) != 0) ? 5'd0 : rs1);
                8:  ins = e_b($urandom_range(0, 8191), ($urandom_range(0, 1) != 0) ? rs1 : rs2, rs1);
                9:  ins = e_j($urandom_range(0, 2097151), rd);
                default: ins = {$urandom_range(0, 33554431), 7'h37};
            endcase
            run_instr(ins, $urandom, $sformatf("rnd%0d", t));
        end

        for (int r = 0; r < 32; r++) begin
            read_rf(r[4:0], v);
            chk($sformatf("final x%0d", r), v, m_reg[r]);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (dmem[i] !== m_dmem[i]) bad++;
        chk("final dmem words differing", bad, 0);
        chk("strobes both high", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
